// File: rtl/instr_fetch_pkg.sv
// Shared widths, reset PC and fetch FSM state type for instr_fetch.
// Also holds the branch-target helper used by the PC update path.
package instr_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

    // Word offset scaled to bytes; the sum wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] branch_target(
        input logic [ADDR_W-1:0] pc4,
        input logic [ADDR_W-1:0] off
    );
        return pc4 + (off << 2);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry prefetch buffer: holds a fetched word and its PC.
// Flush wins over write; a read empties the entry.
module fetch_buf
    import instr_fetch_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_i,
    input  logic [INSTR_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]  wr_pc_i,
    input  logic               rd_i,
    input  logic               flush_i,
    output logic [INSTR_W-1:0] data_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               valid_o
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_data;
    logic [ADDR_W-1:0]  r_pc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (wr_i) begin
            r_valid <= 1'b1;
            r_data  <= wr_data_i;
            r_pc    <= wr_pc_i;
        end else if (rd_i) begin
            r_valid <= 1'b0;
        end
    end

    assign data_o  = r_data;
    assign pc_o    = r_pc;
    assign valid_o = r_valid;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE/REQ/HOLD FSM with valid/ready output.
// Define IF_PREFETCH_EN to fetch pc+4 during HOLD into fetch_buf.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [ADDR_W-1:0]  pc_plus4_o,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_offset_i
);

    fetch_state_e r_state;
    fetch_state_e w_next_state;

    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;

    logic               w_hs;
    logic [ADDR_W-1:0]  w_pc_plus4;
    logic [ADDR_W-1:0]  w_next_pc;
    logic               w_req;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_valid;
    logic               w_ld;
    logic [INSTR_W-1:0] w_ld_data;
    logic               w_pc_we;
    logic [ADDR_W-1:0]  w_pc_d;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_hs       = (r_state == FS_HOLD) && instr_ready_i;
    assign w_next_pc  = branch_taken_i
                      ? branch_target(w_pc_plus4, branch_offset_i)
                      : w_pc_plus4;

`ifdef IF_PREFETCH_EN
    logic               w_buf_valid;
    logic [INSTR_W-1:0] w_buf_data;
    logic [ADDR_W-1:0]  w_buf_pc;
    logic               w_buf_wr;
    logic               w_buf_rd;
    logic               w_flush;
    logic               w_pf_req;
    logic               r_discard;
    logic [ADDR_W-1:0]  r_stale_addr;

    // Prefetch stays requested until acked, since the buffer stays empty.
    assign w_pf_req = (r_state == FS_HOLD) && !w_buf_valid;

    fetch_buf u_fetch_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_i      (w_buf_wr),
        .wr_data_i (imem_data_i),
        .wr_pc_i   (w_pc_plus4),
        .rd_i      (w_buf_rd),
        .flush_i   (w_flush),
        .data_o    (w_buf_data),
        .pc_o      (w_buf_pc),
        .valid_o   (w_buf_valid)
    );

    // A branch abandons an unacked prefetch; its ack must be swallowed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_discard    <= 1'b0;
            r_stale_addr <= '0;
        end else if (w_hs && branch_taken_i && w_pf_req && !imem_ack_i) begin
            r_discard    <= 1'b1;
            r_stale_addr <= w_pc_plus4;
        end else if (r_state == FS_REQ && r_discard && imem_ack_i) begin
            r_discard    <= 1'b0;
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_addr       = r_pc;
        w_valid      = 1'b0;
        w_ld         = 1'b0;
        w_ld_data    = imem_data_i;
        w_pc_we      = w_hs;
        w_pc_d       = w_next_pc;
`ifdef IF_PREFETCH_EN
        w_buf_wr     = 1'b0;
        w_buf_rd     = 1'b0;
        w_flush      = 1'b0;
`endif
        unique case (r_state)
            FS_IDLE: begin
                w_next_state = FS_REQ;
            end
            FS_REQ: begin
                w_req = 1'b1;
`ifdef IF_PREFETCH_EN
                if (r_discard) begin
                    w_addr = r_stale_addr;
                end else if (imem_ack_i) begin
                    w_ld         = 1'b1;
                    w_next_state = FS_HOLD;
                end
`else
                if (imem_ack_i) begin
                    w_ld         = 1'b1;
                    w_next_state = FS_HOLD;
                end
`endif
            end
            FS_HOLD: begin
                w_valid = 1'b1;
`ifdef IF_PREFETCH_EN
                w_req  = w_pf_req;
                w_addr = w_pc_plus4;
                if (w_hs) begin
                    if (branch_taken_i) begin
                        w_flush      = 1'b1;
                        w_next_state = FS_REQ;
                    end else if (w_buf_valid) begin
                        w_ld      = 1'b1;
                        w_ld_data = w_buf_data;
                        w_pc_d    = w_buf_pc;
                        w_buf_rd  = 1'b1;
                    end else if (imem_ack_i) begin
                        w_ld = 1'b1;
                    end else begin
                        w_next_state = FS_REQ;
                    end
                end else if (w_pf_req && imem_ack_i) begin
                    w_buf_wr = 1'b1;
                end
`else
                if (instr_ready_i) begin
                    w_next_state = FS_REQ;
                end
`endif
            end
            default: begin
                w_next_state = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= FS_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_ld) begin
                r_instr <= w_ld_data;
            end
            if (w_pc_we) begin
                r_pc <= w_pc_d;
            end
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = w_addr;
    assign instr_o       = r_instr;
    assign instr_valid_o = w_valid;
    assign pc_o          = r_pc;
    assign pc_plus4_o    = w_pc_plus4;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table plus reset/prefetch sequences.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_instr_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        branch_taken_i;
    logic [31:0] branch_offset_i;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    instr_fetch dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .instr_o         (instr_o),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .branch_taken_i  (branch_taken_i),
        .branch_offset_i (branch_offset_i)
    );

    typedef struct {
        logic [31:0] addr;
        int          ack_dly;
        logic [31:0] data;
        int          rdy_wait;
        logic        br;
        logic [31:0] off;
        logic [31:0] nxt;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl[NV];

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic wait_req();
        int k;
        k = 0;
        while (!imem_req_o && k < 20) begin
            tick();
            k++;
        end
        chk("req_seen", 32'(imem_req_o), 32'd1);
    endtask

    initial begin
        tbl[0] = '{32'h0000_0000, 2, 32'hA000_0001, 0, 1'b0, 32'h0, 32'h0000_0004};
        tbl[1] = '{32'h0000_0004, 0, 32'hA000_0002, 0, 1'b0, 32'h0, 32'h0000_0008};
        tbl[2] = '{32'h0000_0008, 1, 32'hA000_0003, 2, 1'b0, 32'h0, 32'h0000_000C};
        tbl[3] = '{32'h0000_000C, 0, 32'hA000_0004, 0, 1'b0, 32'h0, 32'h0000_0010};
        tbl[4] = '{32'h0000_0010, 1, 32'hA000_0005, 0, 1'b1, 32'hFFFF_FFFE, 32'h0000_000C};
        tbl[5] = '{32'h0000_000C, 0, 32'hA000_0006, 1, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFC};
        tbl[6] = '{32'hFFFF_FFFC, 3, 32'hA000_0007, 0, 1'b0, 32'h0, 32'h0000_0000};
        tbl[7] = '{32'h0000_0000, 0, 32'hA000_0008, 0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[8] = '{32'h0000_0000, 1, 32'hA000_0009, 5, 1'b0, 32'h0, 32'h0000_0004};

        rst_i           = 1'b0;
        imem_ack_i      = 1'b0;
        imem_data_i     = '0;
        instr_ready_i   = 1'b0;
        branch_taken_i  = 1'b0;
        branch_offset_i = '0;
        repeat (3) tick();
        chk("rst_req",    32'(imem_req_o),    32'd0);
        chk("rst_valid",  32'(instr_valid_o), 32'd0);
        chk("rst_instr",  instr_o,            32'h0);
        chk("rst_pc",     pc_o,               32'h0);
        chk("rst_pc4",    pc_plus4_o,         32'h4);
        rst_i = 1'b1;
        tick();

`ifdef IF_PREFETCH_EN
        wait_req();
        chk("pf_addr0", imem_addr_o, 32'h0);
        imem_ack_i  = 1'b1;
        imem_data_i = 32'h0000_0011;
        tick();
        chk("pf_valid0", 32'(instr_valid_o), 32'd1);
        chk("pf_instr0", instr_o, 32'h11);
        chk("pf_req1",   32'(imem_req_o), 32'd1);
        chk("pf_addr1",  imem_addr_o, 32'h4);
        imem_data_i = 32'h0000_0022;
        tick();
        chk("pf_full_req", 32'(imem_req_o), 32'd0);
        chk("pf_hold_pc",  pc_o, 32'h0);
        imem_ack_i    = 1'b0;
        instr_ready_i = 1'b1;
        tick();
        chk("pf_seq_valid", 32'(instr_valid_o), 32'd1);
        chk("pf_seq_instr", instr_o, 32'h22);
        chk("pf_seq_pc",    pc_o, 32'h4);
        chk("pf_req2",      32'(imem_req_o), 32'd1);
        chk("pf_addr2",     imem_addr_o, 32'h8);
        branch_taken_i  = 1'b1;
        branch_offset_i = 32'h3;
        tick();
        instr_ready_i   = 1'b0;
        branch_taken_i  = 1'b0;
        branch_offset_i = '0;
        chk("pf_br_valid", 32'(instr_valid_o), 32'd0);
        chk("pf_br_stale", imem_addr_o, 32'h8);
        imem_ack_i  = 1'b1;
        imem_data_i = 32'h0000_0BAD;
        tick();
        chk("pf_disc_valid", 32'(instr_valid_o), 32'd0);
        chk("pf_disc_req",   32'(imem_req_o), 32'd1);
        chk("pf_tgt_addr",   imem_addr_o, 32'h14);
        imem_data_i = 32'h0000_0033;
        tick();
        imem_ack_i = 1'b0;
        chk("pf_tgt_valid", 32'(instr_valid_o), 32'd1);
        chk("pf_tgt_instr", instr_o, 32'h33);
        chk("pf_tgt_pc",    pc_o, 32'h14);
`else
        for (int i = 0; i < NV; i++) begin
            wait_req();
            chk("fetch_addr", imem_addr_o, tbl[i].addr);
            for (int j = 0; j < tbl[i].ack_dly; j++) begin
                tick();
                chk("req_held", 32'(imem_req_o), 32'd1);
                chk("early_valid", 32'(instr_valid_o), 32'd0);
            end
            imem_ack_i  = 1'b1;
            imem_data_i = tbl[i].data;
            tick();
            imem_ack_i  = 1'b0;
            imem_data_i = '0;
            chk("valid",  32'(instr_valid_o), 32'd1);
            chk("instr",  instr_o, tbl[i].data);
            chk("pc",     pc_o, tbl[i].addr);
            chk("pc4",    pc_plus4_o, tbl[i].addr + 32'd4);
            chk("hold_req", 32'(imem_req_o), 32'd0);
            for (int j = 0; j < tbl[i].rdy_wait; j++) begin
                branch_taken_i  = 1'b1;
                branch_offset_i = 32'h0000_0100;
                imem_ack_i      = 1'b1;
                imem_data_i     = 32'hDEAD_BEEF;
                tick();
                chk("stall_instr", instr_o, tbl[i].data);
                chk("stall_pc",    pc_o, tbl[i].addr);
                chk("stall_valid", 32'(instr_valid_o), 32'd1);
                chk("stall_req",   32'(imem_req_o), 32'd0);
            end
            imem_ack_i      = 1'b0;
            imem_data_i     = '0;
            branch_taken_i  = tbl[i].br;
            branch_offset_i = tbl[i].off;
            instr_ready_i   = 1'b1;
            tick();
            instr_ready_i   = 1'b0;
            branch_taken_i  = 1'b0;
            branch_offset_i = '0;
            chk("lat_req",   32'(imem_req_o), 32'd1);
            chk("next_addr", imem_addr_o, tbl[i].nxt);
            chk("hs_valid",  32'(instr_valid_o), 32'd0);
        end
`endif

        chk("pre_rst_req", 32'(imem_req_o), 32'd1);
        rst_i = 1'b0;
        tick();
        chk("mid_rst_req",   32'(imem_req_o), 32'd0);
        chk("mid_rst_valid", 32'(instr_valid_o), 32'd0);
        chk("mid_rst_pc",    pc_o, 32'h0);
        rst_i       = 1'b1;
        imem_ack_i  = 1'b1;
        imem_data_i = 32'h0000_0BAD;
        tick();
        imem_ack_i  = 1'b0;
        imem_data_i = '0;
        chk("late_ack_valid", 32'(instr_valid_o), 32'd0);
        chk("restart_req",    32'(imem_req_o), 32'd1);
        chk("restart_addr",   imem_addr_o, 32'h0);
        tick();
        chk("restart_wait", 32'(instr_valid_o), 32'd0);
        imem_ack_i  = 1'b1;
        imem_data_i = 32'h0000_600D;
        tick();
        imem_ack_i  = 1'b0;
        chk("restart_valid", 32'(instr_valid_o), 32'd1);
        chk("restart_instr", instr_o, 32'h600D);
        chk("restart_pc",    pc_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk_i  in  1  system clock; all state changes on rising edge.
REQ-003 rst_i  in  1  asynchronous, active-low reset.
REQ-004 imem_req_o  out  1  instruction-memory read request; held high until imem_ack_i.
REQ-005 imem_addr_o  out  32  byte address of the requested word; bits [1:0] always 0.
REQ-006 imem_ack_i  in  1  memory return strobe; imem_data_i is valid in this cycle.
REQ-007 imem_data_i  in  32  returned instruction word.
REQ-008 instr_o  out  32  current instruction; [31:26] drives the decoder opcode input.
REQ-009 instr_valid_o  out  1  instr_o, pc_o and pc_plus4_o are valid.
REQ-010 instr_ready_i  in  1  downstream consumes the instruction when instr_valid_o is also high (handshake).
REQ-011 pc_o / pc_plus4_o  out  32 each  address of instr_o, and that address + 4.
REQ-012 branch_taken_i  in  1  redirect request, sampled only in the handshake cycle.
REQ-013 branch_offset_i  in  32  sign-extended word offset, sampled with branch_taken_i.

Function
REQ-014 The FSM SHALL have the states IDLE, REQ and HOLD.
REQ-015 IDLE SHALL move to REQ in the first clock after reset release.
REQ-016 REQ SHALL assert imem_req_o with imem_addr_o = PC, and move to HOLD on imem_ack_i, capturing imem_data_i into instr_o.
REQ-017 HOLD SHALL assert instr_valid_o, with instr_o, pc_o and pc_plus4_o held stable, until the handshake.
REQ-018 On handshake the next PC SHALL be pc_plus4_o + (branch_offset_i << 2) if branch_taken_i is high, otherwise pc_plus4_o; the FSM then returns to REQ.
REQ-019 PC arithmetic SHALL be modulo 2^32: 0xFFFFFFFC + 4 = 0x00000000, and the branch sum wraps silently.
REQ-020 imem_ack_i SHALL be ignored whenever imem_req_o is low, or whenever no request is outstanding.
REQ-021 Fetch latency SHALL be: request asserted 1 cycle after PC update; instr_valid_o asserted 1 cycle after the ack.
REQ-022 branch_taken_i and branch_offset_i SHALL be ignored outside the handshake cycle.

Reset
REQ-023 Reset SHALL give: PC = RESET_PC (0x00000000), state IDLE, imem_req_o = 0, instr_valid_o = 0, instr_o = 0, pc_o = 0, pc_plus4_o = 4.
REQ-024 Reset asserted mid-operation SHALL abandon any outstanding request; an ack arriving after reset SHALL be discarded per REQ-020.

Configuration
REQ-025 With IF_PREFETCH_EN defined:
  - in HOLD the block SHALL issue the fetch for pc_plus4_o into a one-entry prefetch buffer;
  - on a sequential handshake with the buffer full, the buffered word SHALL be presented in the next cycle, with no REQ cycle;
  - on a taken branch the buffer SHALL be flushed and any in-flight ack discarded.
REQ-026 Without IF_PREFETCH_EN, at most one request SHALL be outstanding and only REQ/HOLD behaviour applies; results are cycle-identical to REQ-014..022.

Structure
REQ-027 A shared package SHALL hold: RESET_PC, the INSTR_W/ADDR_W widths, and the fetch-state enum typedef.
REQ-028 The prefetch buffer SHALL be the sub-module fetch_buf (data, pc, valid, flush), instantiated only under IF_PREFETCH_EN.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
  - Reset release, ack after 2 cycles -> imem_addr_o = 0x0; instr_valid_o high with pc_o = 0x0 and pc_plus4_o = 0x4.
  - instr_ready_i held low for 5 cycles -> instr_o and pc_o stable, imem_req_o low (no prefetch build).
  - Handshake at pc_o = 0x10 with branch_taken_i = 1, branch_offset_i = 0xFFFFFFFE -> next imem_addr_o = 0x0C.
  - PC = 0xFFFFFFFC, sequential handshake -> next imem_addr_o = 0x00000000.
  - Reset pulsed while imem_req_o is high, ack arriving 1 cycle later -> instr_valid_o stays 0 and the fetch restarts at 0x0.
  - IF_PREFETCH_EN build: sequential consume -> next instruction valid 1 cycle after handshake; taken branch -> buffer flushed and the fetch goes to the target.
